// File: rtl/local_ni_pkg.sv
// Shared flit layout, field widths and injection FSM encoding for the local
// network interface.
package local_ni_pkg;

   localparam int FLIT_W    = 30;
   localparam int MASK_W    = 9;
   localparam int ID_W      = 4;
   localparam int PAYLOAD_W = 16;

   localparam int TYPE_BIT  = 29;
   localparam int DST_HI    = 28;
   localparam int DST_LO    = 25;
   localparam int MASK_HI   = 28;
   localparam int MASK_LO   = 20;
   localparam int SRC_HI    = 19;
   localparam int SRC_LO    = 16;
   localparam int PAY_HI    = 15;
   localparam int PAY_LO    = 0;

   localparam logic TYPE_UNI = 1'b0;
   localparam logic TYPE_MC  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_LOOP = 2'd2
   } ni_state_t;

   // Unicast flits carry a zero pad where a multicast mask would have its low bits.
   function automatic logic [FLIT_W-1:0] make_uni_flit(
      input logic [ID_W-1:0]      dst,
      input logic [ID_W-1:0]      src,
      input logic [PAYLOAD_W-1:0] payload
   );
      return {TYPE_UNI, dst, 5'd0, src, payload};
   endfunction

   function automatic logic [FLIT_W-1:0] make_mc_flit(
      input logic [MASK_W-1:0]    mask,
      input logic [ID_W-1:0]      src,
      input logic [PAYLOAD_W-1:0] payload
   );
      return {TYPE_MC, mask, src, payload};
   endfunction

endpackage

// File: rtl/ni_eject_fifo.sv
// First-word fall-through ejection FIFO; router writes win over loopback writes
// and router flits arriving while full are dropped and counted.
module ni_eject_fifo
   import local_ni_pkg::*;
#(
   parameter int DATASIZE = 30,
   parameter int WIDTH    = 2,
   parameter int DEPTH    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rtr_valid,
   input  logic [DATASIZE-1:0] rtr_data,
   input  logic                loop_valid,
   input  logic [DATASIZE-1:0] loop_data,
   input  logic                pop_req,
   output logic                rx_valid,
   output logic [DATASIZE-1:0] rx_data,
   output logic                full,
   output logic [7:0]          drop_cnt
);

   logic [WIDTH:0]    wr_ptr_reg;
   logic [WIDTH:0]    rd_ptr_reg;
   logic [7:0]        drop_cnt_reg;
   logic [DATASIZE-1:0] mem [DEPTH];

   logic                empty;
   logic                pop;
   logic                wr_req;
   logic                wr_en;
   logic                drop;
   logic [DATASIZE-1:0] wr_data;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[WIDTH] != rd_ptr_reg[WIDTH]) &&
                  (wr_ptr_reg[WIDTH-1:0] == rd_ptr_reg[WIDTH-1:0]);

   assign pop     = pop_req & ~empty;
   assign wr_req  = rtr_valid | loop_valid;
   assign wr_data = rtr_valid ? rtr_data : loop_data;
   // A pop in the same cycle frees the slot the write lands in.
   assign wr_en   = wr_req & (~full | pop);
   assign drop    = rtr_valid & full & ~pop;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg[WIDTH-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         drop_cnt_reg <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
         end
      end
   end

   assign rx_valid = ~empty;
   assign rx_data  = mem[rd_ptr_reg[WIDTH-1:0]];
   assign drop_cnt = drop_cnt_reg;

endmodule

// File: rtl/local_ni.sv
// Network interface between a PE and a router local port: packs requests into
// flits, injects them with backpressure, and loops self-addressed copies back.
module local_ni
   import local_ni_pkg::*;
#(
   parameter int DATASIZE  = 30,
   parameter int WIDTH     = 2,
   parameter int DEPTH     = 4,
   parameter int router_ID = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic                 tx_mcast,
   input  logic [ID_W-1:0]      tx_dst,
   input  logic [MASK_W-1:0]    tx_mask,
   input  logic [PAYLOAD_W-1:0] tx_payload,
   output logic [DATASIZE-1:0]  rtr_data_out,
   output logic                 rtr_valid_out,
   input  logic                 rtr_full_in,
   input  logic [DATASIZE-1:0]  rtr_data_in,
   input  logic                 rtr_valid_in,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic [DATASIZE-1:0]  rx_data,
   output logic [7:0]           drop_cnt
);

   localparam logic [ID_W-1:0]   SELF_ID   = ID_W'(router_ID);
   localparam logic [MASK_W-1:0] SELF_MASK = MASK_W'(1) << router_ID;

   ni_state_t           state_reg, state_next;
   logic [DATASIZE-1:0] flit_reg, flit_next;
   logic                flit_valid_reg, flit_valid_next;
   logic                loop_pending_reg, loop_pending_next;
   logic [DATASIZE-1:0] loop_flit_reg, loop_flit_next;

   logic                loop_wr;
   logic                fifo_full;
   logic [MASK_W-1:0]   mc_other;
   logic                mc_self;
   logic [DATASIZE-1:0] uni_flit;
   logic [DATASIZE-1:0] mc_fwd_flit;
   logic [DATASIZE-1:0] mc_self_flit;

   assign mc_other     = tx_mask & ~SELF_MASK;
   assign mc_self      = |(tx_mask & SELF_MASK);
   assign uni_flit     = make_uni_flit(tx_dst, SELF_ID, tx_payload);
   assign mc_fwd_flit  = make_mc_flit(mc_other, SELF_ID, tx_payload);
   assign mc_self_flit = make_mc_flit(SELF_MASK, SELF_ID, tx_payload);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= ST_IDLE;
         flit_reg         <= '0;
         flit_valid_reg   <= 1'b0;
         loop_pending_reg <= 1'b0;
         loop_flit_reg    <= '0;
      end else begin
         state_reg        <= state_next;
         flit_reg         <= flit_next;
         flit_valid_reg   <= flit_valid_next;
         loop_pending_reg <= loop_pending_next;
         loop_flit_reg    <= loop_flit_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      flit_next         = flit_reg;
      flit_valid_next   = flit_valid_reg;
      loop_pending_next = loop_pending_reg;
      loop_flit_next    = loop_flit_reg;
      tx_ready          = 1'b0;
      rtr_valid_out     = 1'b0;
      loop_wr           = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            tx_ready = 1'b1;
            if (tx_valid) begin
               if (tx_mcast == TYPE_UNI) begin
                  flit_next      = uni_flit;
                  loop_flit_next = uni_flit;
                  if (tx_dst == SELF_ID) begin
                     state_next = ST_LOOP;
                  end else begin
                     flit_valid_next = 1'b1;
                     state_next      = ST_SEND;
                  end
               end else if (mc_other != '0) begin
                  // Remote copy goes out with the self bit stripped; the self copy follows via LOOP.
                  flit_next         = mc_fwd_flit;
                  flit_valid_next   = 1'b1;
                  loop_flit_next    = mc_self_flit;
                  loop_pending_next = mc_self;
                  state_next        = ST_SEND;
               end else if (mc_self) begin
                  flit_next      = mc_self_flit;
                  loop_flit_next = mc_self_flit;
                  state_next     = ST_LOOP;
               end
               // An empty mask is accepted and silently discarded.
            end
         end

         ST_SEND: begin
            rtr_valid_out = flit_valid_reg & ~rtr_full_in;
            if (rtr_valid_out) begin
               flit_valid_next = 1'b0;
               state_next      = loop_pending_reg ? ST_LOOP : ST_IDLE;
            end
         end

         ST_LOOP: begin
            // The router cannot be stalled, so loopback yields to any router delivery.
            if (!fifo_full && !rtr_valid_in) begin
               loop_wr           = 1'b1;
               loop_pending_next = 1'b0;
               state_next        = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign rtr_data_out = flit_reg;

   ni_eject_fifo #(
      .DATASIZE (DATASIZE),
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH)
   ) u_eject_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .rtr_valid  (rtr_valid_in),
      .rtr_data   (rtr_data_in),
      .loop_valid (loop_wr),
      .loop_data  (loop_flit_reg),
      .pop_req    (rx_ready),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .full       (fifo_full),
      .drop_cnt   (drop_cnt)
   );

endmodule

// File: tb/tb_local_ni.sv
// Directed bench for local_ni: a request table for injection/loopback routing
// plus hand sequences for backpressure, ejection ordering, overflow and reset.
module tb_local_ni;

   logic        clk;
   logic        rst_n;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_mcast;
   logic [3:0]  tx_dst;
   logic [8:0]  tx_mask;
   logic [15:0] tx_payload;
   logic [29:0] rtr_data_out;
   logic        rtr_valid_out;
   logic        rtr_full_in;
   logic [29:0] rtr_data_in;
   logic        rtr_valid_in;
   logic        rx_valid;
   logic        rx_ready;
   logic [29:0] rx_data;
   logic [7:0]  drop_cnt;

   int checks   = 0;
   int failures = 0;

   local_ni #(
      .DATASIZE  (30),
      .WIDTH     (2),
      .DEPTH     (4),
      .router_ID (6)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .tx_mcast      (tx_mcast),
      .tx_dst        (tx_dst),
      .tx_mask       (tx_mask),
      .tx_payload    (tx_payload),
      .rtr_data_out  (rtr_data_out),
      .rtr_valid_out (rtr_valid_out),
      .rtr_full_in   (rtr_full_in),
      .rtr_data_in   (rtr_data_in),
      .rtr_valid_in  (rtr_valid_in),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_data       (rx_data),
      .drop_cnt      (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mcast;
      logic [3:0]  dst;
      logic [8:0]  mask;
      logic [15:0] payload;
      int          n_tx;
      logic [29:0] tx_flit;
      int          n_rx;
      logic [29:0] rx_flit;
      int          busy;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s = 0x%0h", name, act);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n_tx, n_rx, n_busy;
      logic [29:0] got_tx, got_rx;
      logic [29:0] exp_flit;
      logic [29:0] pop_exp[4];

      // mcast, dst, mask, payload, n_tx, tx_flit, n_rx, rx_flit, busy cycles
      vecs[0] = '{1'b0, 4'd2, 9'h1FF, 16'hBEEF, 1, {1'b0, 4'd2, 5'd0, 4'd6, 16'hBEEF}, 0, 30'd0, 1};
      vecs[1] = '{1'b0, 4'd6, 9'h000, 16'h1234, 0, 30'd0, 1, {1'b0, 4'd6, 5'd0, 4'd6, 16'h1234}, 1};
      vecs[2] = '{1'b1, 4'd0, 9'b0_0100_0101, 16'hA5A5, 1, {1'b1, 9'b0_0000_0101, 4'd6, 16'hA5A5},
                  1, {1'b1, 9'b0_0100_0000, 4'd6, 16'hA5A5}, 2};
      vecs[3] = '{1'b1, 4'd0, 9'b0_0100_0000, 16'h0F0F, 0, 30'd0, 1, {1'b1, 9'b0_0100_0000, 4'd6, 16'h0F0F}, 1};
      vecs[4] = '{1'b1, 4'd0, 9'h000, 16'hDEAD, 0, 30'd0, 0, 30'd0, 0};
      vecs[5] = '{1'b1, 4'd0, 9'b1_1000_0000, 16'h0001, 1, {1'b1, 9'b1_1000_0000, 4'd6, 16'h0001}, 0, 30'd0, 1};
      vecs[6] = '{1'b0, 4'd8, 9'h040, 16'hFFFF, 1, {1'b0, 4'd8, 5'd0, 4'd6, 16'hFFFF}, 0, 30'd0, 1};

      rst_n = 1'b0; tx_valid = 1'b0; tx_mcast = 1'b0; tx_dst = '0; tx_mask = '0; tx_payload = '0;
      rtr_full_in = 1'b0; rtr_data_in = '0; rtr_valid_in = 1'b0; rx_ready = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_rtr_valid_out", 32'(rtr_valid_out), 32'd0);
      check("rst_rtr_data_out", 32'(rtr_data_out), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven requests with the router never full.
      for (int i = 0; i < 7; i++) begin
         tx_valid = 1'b1; tx_mcast = vecs[i].mcast; tx_dst = vecs[i].dst;
         tx_mask = vecs[i].mask; tx_payload = vecs[i].payload;
         @(negedge clk);
         tx_valid = 1'b0;
         n_tx = 0; n_rx = 0; n_busy = 0; got_tx = '0; got_rx = '0;
         for (int c = 0; c < 8; c++) begin
            if (rtr_valid_out) begin n_tx++; got_tx = rtr_data_out; end
            if (!tx_ready) n_busy++;
            if (rx_valid) begin n_rx++; got_rx = rx_data; rx_ready = 1'b1; end
            else rx_ready = 1'b0;
            @(negedge clk);
         end
         rx_ready = 1'b0;
         check($sformatf("vec%0d_tx_count", i), 32'(n_tx), 32'(vecs[i].n_tx));
         if (vecs[i].n_tx > 0) check($sformatf("vec%0d_tx_flit", i), 32'(got_tx), 32'(vecs[i].tx_flit));
         check($sformatf("vec%0d_rx_count", i), 32'(n_rx), 32'(vecs[i].n_rx));
         if (vecs[i].n_rx > 0) check($sformatf("vec%0d_rx_flit", i), 32'(got_rx), 32'(vecs[i].rx_flit));
         check($sformatf("vec%0d_busy_cycles", i), 32'(n_busy), 32'(vecs[i].busy));
      end

      // Backpressure: router full for 5 cycles, flit held, then exactly one transfer.
      exp_flit = {1'b0, 4'd2, 5'd0, 4'd6, 16'hBEEF};
      rtr_full_in = 1'b1;
      tx_valid = 1'b1; tx_mcast = 1'b0; tx_dst = 4'd2; tx_payload = 16'hBEEF;
      @(negedge clk);
      tx_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("bp_hold_valid_c%0d", c), 32'(rtr_valid_out), 32'd0);
         check($sformatf("bp_hold_data_c%0d", c), 32'(rtr_data_out), 32'(exp_flit));
         if (c < 4) @(negedge clk);
      end
      rtr_full_in = 1'b0;
      #1;
      check("bp_release_valid", 32'(rtr_valid_out), 32'd1);
      check("bp_release_data", 32'(rtr_data_out), 32'(exp_flit));
      @(negedge clk);
      check("bp_after_valid", 32'(rtr_valid_out), 32'd0);
      check("bp_after_tx_ready", 32'(tx_ready), 32'd1);

      // Loopback collides with a router delivery: router flit goes first.
      tx_valid = 1'b1; tx_mcast = 1'b0; tx_dst = 4'd6; tx_payload = 16'h5555;
      @(negedge clk);
      tx_valid = 1'b0;
      rtr_valid_in = 1'b1; rtr_data_in = 30'h1ABC_1234;
      @(negedge clk);
      rtr_valid_in = 1'b0;
      check("order_first_valid", 32'(rx_valid), 32'd1);
      check("order_first_data", 32'(rx_data), 32'h1ABC_1234);
      rx_ready = 1'b1;
      @(negedge clk);
      check("order_second_valid", 32'(rx_valid), 32'd1);
      check("order_second_data", 32'(rx_data), 32'({1'b0, 4'd6, 5'd0, 4'd6, 16'h5555}));
      @(negedge clk);
      rx_ready = 1'b0;
      check("order_drained", 32'(rx_valid), 32'd0);

      // Overflow: six router flits with no pops.
      for (int k = 0; k < 6; k++) begin
         rtr_valid_in = 1'b1; rtr_data_in = 30'(32'h100 + k);
         @(negedge clk);
      end
      rtr_valid_in = 1'b0;
      check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
      check("ovf_head", 32'(rx_data), 32'h100);
      // Write plus pop while full: both succeed, nothing dropped.
      rtr_valid_in = 1'b1; rtr_data_in = 30'h200; rx_ready = 1'b1;
      @(negedge clk);
      rtr_valid_in = 1'b0; rx_ready = 1'b0;
      check("full_wr_pop_drop_cnt", 32'(drop_cnt), 32'd2);
      check("full_wr_pop_head", 32'(rx_data), 32'h101);
      // Drop counter saturates.
      rtr_valid_in = 1'b1; rtr_data_in = 30'h3FF;
      repeat (260) @(negedge clk);
      rtr_valid_in = 1'b0;
      check("drop_saturate", 32'(drop_cnt), 32'd255);
      pop_exp[0] = 30'h101; pop_exp[1] = 30'h102; pop_exp[2] = 30'h103; pop_exp[3] = 30'h200;
      rx_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("pop%0d_valid", k), 32'(rx_valid), 32'd1);
         check($sformatf("pop%0d_data", k), 32'(rx_data), 32'(pop_exp[k]));
         @(negedge clk);
      end
      rx_ready = 1'b0;
      check("pop_empty", 32'(rx_valid), 32'd0);

      // Reset in the middle of SEND with a flit parked in the FIFO.
      rtr_valid_in = 1'b1; rtr_data_in = 30'h77;
      @(negedge clk);
      rtr_valid_in = 1'b0;
      tx_valid = 1'b1; tx_mcast = 1'b0; tx_dst = 4'd2; tx_payload = 16'hCAFE;
      @(negedge clk);
      tx_valid = 1'b0;
      check("rst_mid_send_valid_before", 32'(rtr_valid_out), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_valid_out", 32'(rtr_valid_out), 32'd0);
      check("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_mid_drop_cnt", 32'(drop_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_after_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_after_valid_out", 32'(rtr_valid_out), 32'd0);
      check("rst_after_rx_valid", 32'(rx_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
